// File: rtl/f5_flatten_reader.sv
// f5_flatten_reader: sweeps F5 storage map-major and streams the 400 values to F6
// through a small output FIFO whose free space gates every storage read.
module f5_flatten_reader #(
    parameter int ADDRS      = 25,
    parameter int MAPS       = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  f5_raddr,
    output logic [3:0]  f5_sel,
    input  logic [15:0] f5_rdata,
    output logic [15:0] out_data,
    output logic [8:0]  out_index,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, LEAD, ISSUE, DRAIN} state_t;

    state_t           state_q;
    logic             busy_q, done_q;
    logic [4:0]       addr_q;
    logic [3:0]       map_q;
    logic [8:0]       idx_q;
    logic [RD_LAT-1:0] v_q, v_d;
    logic [8:0]       pidx_q [RD_LAT];
    logic [15:0]      fd_q [FIFO_DEPTH];
    logic [8:0]       fi_q [FIFO_DEPTH];
    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    infl;
    logic             credit_ok, issue, wr, rd, drained;

    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) infl = infl + LW'(v_q[i]);
    end

    // Counting in-flight reads as occupied slots means a returning word always finds room.
    assign credit_ok = (int'(cnt_q) + int'(infl)) < FIFO_DEPTH;
    assign issue     = (state_q == ISSUE) && credit_ok;
    assign wr        = v_q[RD_LAT-1];
    assign rd        = out_valid && out_ready;
    assign cnt_d     = cnt_q + CW'(wr) - CW'(rd);
    assign v_d       = RD_LAT'({v_q, issue});
    assign drained   = (v_d == '0) && (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            map_q   <= '0;
            idx_q   <= '0;
            v_q     <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) pidx_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fd_q[i] <= '0;
                fi_q[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            v_q       <= v_d;
            pidx_q[0] <= idx_q;
            for (int i = 1; i < RD_LAT; i++) pidx_q[i] <= pidx_q[i-1];
            if (wr) begin
                fd_q[wp_q] <= f5_rdata;
                fi_q[wp_q] <= pidx_q[RD_LAT-1];
                wp_q       <= wp_q + PW'(1);
            end
            if (rd) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_d;
            if (issue) idx_q <= idx_q + 9'd1;
            case (state_q)
                IDLE: begin
                    busy_q <= start && !busy_q;
                    if (start && !busy_q) begin
                        state_q <= LEAD;
                        addr_q  <= '0;
                        map_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                LEAD: state_q <= ISSUE;
                // A new lane needs a LEAD bubble because the storage applies f5_sel one cycle late.
                ISSUE: if (issue) begin
                    if (addr_q != 5'(ADDRS - 1)) addr_q <= addr_q + 5'd1;
                    else if (map_q != 4'(MAPS - 1)) begin
                        map_q   <= map_q + 4'd1;
                        addr_q  <= '0;
                        state_q <= LEAD;
                    end else state_q <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign f5_raddr  = addr_q;
    assign f5_sel    = map_q;
    assign out_valid = cnt_q != '0;
    assign out_data  = fd_q[rp_q];
    assign out_index = fi_q[rp_q];
    assign out_last  = out_valid && (out_index == 9'(ADDRS * MAPS - 1));
endmodule

// File: doc/f5_flatten_reader.md
# f5_flatten_reader

Read-side sequencer for the F5 feature-map storage. On a start pulse it sweeps all 16 lanes × 25 addresses of F5 storage in map-major order. It drives `f5_raddr`/`f5_sel` and realigns the returned `f5_rdata` with the storage read latency. It delivers the 400 values as a flattened valid/ready stream, indexed 0..399, to the F6 fully-connected stage. Issue is credit-limited so downstream backpressure never drops data.

## Interface
- `ADDRS`, 25: F5 addresses per map (5×5 positions).
- `MAPS`, 16: F5 lanes/maps.
- `RD_LAT`, 2: cycles from `f5_raddr` issue to matching `f5_rdata`.
- `FIFO_DEPTH`, 4: output buffer depth; also the credit limit.
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: one-cycle request to begin a sweep; ignored while `busy`=1.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `f5_raddr` out 5: storage read address, 0..24.
- `f5_sel` out 4: storage lane select, 0..15.
- `f5_rdata` in 16: storage read data.
- `out_data` out 16: flattened value (FIFO head).
- `out_index` out 9: flattened index, map*25 + addr.
- `out_last` out 1: high with the beat whose `out_index`=399.
- `out_valid` out 1: beat present.
- `out_ready` in 1: beat accepted when `out_valid` & `out_ready`.

## Operation
- F5 storage contract:
  - `f5_rdata` in cycle t+2 = mem[`f5_raddr`(t)], lane `f5_sel`(t-1).
  - The lane select therefore takes effect one cycle late, so `f5_sel` must hold the same value in cycles t-1 and t for every issue at cycle t.
- FSM states: IDLE, LEAD, ISSUE, DRAIN.
  - IDLE: `start`=1 → LEAD. Clear map/addr counters to 0 and the index counter to 0.
  - LEAD: one bubble. `f5_sel`=map, `f5_raddr`=0, no issue. Go to ISSUE.
  - ISSUE: issue when `credit_ok` = (fifo_count + inflight) < FIFO_DEPTH. Otherwise stall, holding addr and sel.
    - On issue with addr<24: addr+1.
    - On issue with addr=24 and map<15: map+1, addr=0, go to LEAD.
    - On issue with addr=24 and map=15: go to DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty. Then pulse `done` and go to IDLE.
- In-flight tracking: an RD_LAT-deep valid shift register plus an index shift register carry each issue's index.
  - The returned word is written into the FIFO in the cycle its valid bit reaches the end of the shift register.
- Credit rule guarantees a FIFO write never meets a full FIFO. Overflow is a design error; flag it as an assertion in the bench.
- FIFO is registered. A word written at the end of cycle c is visible on `out_*` in cycle c+1.
  - Simultaneous FIFO read and write is allowed at any occupancy, including empty→pass and full.
- `out_index` increments 0..399 with no gaps or repeats. `out_last` is asserted only with index 399.
- `start` arriving while `busy`=1 is ignored with no side effect.
- Reset (`rst_n`=0 at a posedge):
  - Returns to IDLE from any state, including mid-sweep.
  - Empties the FIFO and in-flight pipe.
  - Clears all counters.
  - Drives `busy`, `done`, `out_valid`, `out_last`, `f5_raddr`, `f5_sel`, `out_data` and `out_index` to 0.
  - Data returning from the storage after reset is discarded.

## Timing
- `start` sampled in cycle 0 → LEAD in cycle 1 → first issue (map 0, addr 0) in cycle 2.
  - Data returns in cycle 4, is written into the FIFO at the end of cycle 4, and `out_valid`=1 in cycle 5.
- With `out_ready` held at 1:
  - Issue cycles span cycles 1..416 (16 × (1 LEAD + 25 issue)).
  - Last beat (`out_last`) in cycle 419; `done` in cycle 420; `busy`=0 from cycle 421.
- Output throughput with no stall is 1 beat/cycle, except one bubble per map boundary.
- With `out_ready`=0, at most FIFO_DEPTH issues are outstanding. Issue resumes the cycle after a beat is accepted.

## Test plan
- Bench setup:
  - Behavioural storage model obeys the contract in Operation.
  - Storage content: lane m, addr a = {m[7:0], a[7:0]}.
  - All scenarios check that the FIFO never overflows.
- Full sweep, `out_ready`=1 → 400 beats, with beat i = {i/25, i%25}, `out_index`=i, and `out_last` only at i=399. `done` pulses in cycle 420 after start.
- `out_ready`=0 from cycle 3 for 20 cycles, then 1 → exactly 4 beats buffered, no loss or duplication, and the stream is identical to the full-sweep result.
- Random `out_ready` (50%) → identical 400-beat sequence. `done` follows the last accepted beat by 1 cycle.
- Map boundary: check `f5_sel` is stable in the cycle before every issue → beat 25 = 0x0100 and beat 24 = 0x0018.
- `start` re-pulsed at cycle 100 mid-sweep → ignored, single `done`, still 400 beats.
- `rst_n`=0 at cycle 150 mid-sweep → all outputs 0 the next cycle. A new `start` then yields a fresh 400-beat sweep starting at index 0.
